// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if
// Bus bundle for the multi-port register file.
//   rs        : packed read addresses, port i at rs[i*AW +: AW]
//   val       : packed read data, port i at val[i*XLEN +: XLEN]
//   pending   : per read port, addressed register has an outstanding producer
//   rd        : packed write addresses, port j at rd[j*AW +: AW]
//   valR      : packed write data, port j at valR[j*XLEN +: XLEN]
//   write_en  : per write port enable
//   claim_en  : mark claim_rd busy (issue)
//   claim_rd  : register to claim
//   busy_mask : raw busy flop per register
// master = decode/issue/writeback side, slave = register file.
interface reg_file_mp_if #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NUM_READ*AW-1:0]    rs;
    logic [NUM_READ*XLEN-1:0]  val;
    logic [NUM_READ-1:0]       pending;
    logic [NUM_WRITE*AW-1:0]   rd;
    logic [NUM_WRITE*XLEN-1:0] valR;
    logic [NUM_WRITE-1:0]      write_en;
    logic                      claim_en;
    logic [AW-1:0]             claim_rd;
    logic [NREGS-1:0]          busy_mask;

    modport master (
        output rs, rd, valR, write_en, claim_en, claim_rd,
        input  val, pending, busy_mask
    );

    modport slave (
        input  rs, rd, valR, write_en, claim_en, claim_rd,
        output val, pending, busy_mask
    );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp
// Parametrised register file with NUM_READ combinational read ports,
// NUM_WRITE registered write ports, optional hardwired zero register,
// optional same-cycle write-to-read bypass and per-register busy bits.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears data and busy bits
//   bus     : reg_file_mp_if slave modport (reads, writes, claims, busy_mask)
module reg_file_mp #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 1,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    reg_file_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]          regs_q [NREGS];
    logic [XLEN-1:0]          regs_d [NREGS];
    logic [NREGS-1:0]         busy_q;
    logic [NREGS-1:0]         busy_d;

    logic [NUM_READ*XLEN-1:0] val_c;
    logic [NUM_READ-1:0]      pend_c;
    logic [AW-1:0]            ra;
    logic [XLEN-1:0]          rv;
    logic                     rp;

    // An address is usable when it names an implemented register and is not
    // the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !((ZERO_REG0 != 0) && (a == '0));
    endfunction

    // Write and busy update. Ports are walked in ascending order so the
    // highest-numbered port wins a same-register collision; the claim is
    // applied last so a new producer supersedes a retiring one.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (bus.write_en[j] && addr_ok(bus.rd[j*AW +: AW])) begin
                regs_d[bus.rd[j*AW +: AW]] = bus.valR[j*XLEN +: XLEN];
                busy_d[bus.rd[j*AW +: AW]] = 1'b0;
            end
        end
        if (bus.claim_en && addr_ok(bus.claim_rd)) begin
            busy_d[bus.claim_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read path. Gated by reset_n so bypassed write data cannot leak out
    // while the array is held in reset.
    always_comb begin
        val_c  = '0;
        pend_c = '0;
        ra     = '0;
        rv     = '0;
        rp     = 1'b0;
        for (int i = 0; i < NUM_READ; i++) begin
            ra = bus.rs[i*AW +: AW];
            rv = '0;
            rp = 1'b0;
            if (reset_n && addr_ok(ra)) begin
                rv = regs_q[ra];
                rp = busy_q[ra];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NUM_WRITE; j++) begin
                        if (bus.write_en[j] && (bus.rd[j*AW +: AW] == ra)) begin
                            rv = bus.valR[j*XLEN +: XLEN];
                            rp = 1'b0;
                        end
                    end
                end
            end
            val_c[i*XLEN +: XLEN] = rv;
            pend_c[i]             = rp;
        end
    end

    assign bus.val       = val_c;
    assign bus.pending   = pend_c;
    assign bus.busy_mask = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp
// Directed bench for reg_file_mp with three configurations sharing one
// clock and reset:
//   u0 : NREGS=32, BYPASS=0, NUM_WRITE=1
//   u1 : NREGS=32, BYPASS=1, NUM_WRITE=2
//   u2 : NREGS=20, BYPASS=1, NUM_WRITE=1
module tb_reg_file_mp;
    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    reg_file_mp_if #(.XLEN(32), .NREGS(32), .NUM_READ(2), .NUM_WRITE(1)) b0 ();
    reg_file_mp_if #(.XLEN(32), .NREGS(32), .NUM_READ(2), .NUM_WRITE(2)) b1 ();
    reg_file_mp_if #(.XLEN(32), .NREGS(20), .NUM_READ(2), .NUM_WRITE(1)) b2 ();

    reg_file_mp #(.XLEN(32), .NREGS(32), .NUM_READ(2), .NUM_WRITE(1),
                  .BYPASS(0), .ZERO_REG0(1))
        u0 (.clock(clk), .reset_n(reset_n), .bus(b0));
    reg_file_mp #(.XLEN(32), .NREGS(32), .NUM_READ(2), .NUM_WRITE(2),
                  .BYPASS(1), .ZERO_REG0(1))
        u1 (.clock(clk), .reset_n(reset_n), .bus(b1));
    reg_file_mp #(.XLEN(32), .NREGS(20), .NUM_READ(2), .NUM_WRITE(1),
                  .BYPASS(1), .ZERO_REG0(1))
        u2 (.clock(clk), .reset_n(reset_n), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        b0.rs = '0; b0.rd = '0; b0.valR = '0; b0.write_en = '0;
        b0.claim_en = 1'b0; b0.claim_rd = '0;
        b1.rs = '0; b1.rd = '0; b1.valR = '0; b1.write_en = '0;
        b1.claim_en = 1'b0; b1.claim_rd = '0;
        b2.rs = '0; b2.rd = '0; b2.valR = '0; b2.write_en = '0;
        b2.claim_en = 1'b0; b2.claim_rd = '0;

        // Reset held: outputs forced low even with a live bypass write.
        #2;
        b1.rs = {5'd0, 5'd3};
        b1.rd = {5'd0, 5'd3};
        b1.valR = {32'h0, 32'h0000_0005};
        b1.write_en = 2'b01;
        #1;
        chk("rst_val_bypass", b1.val, 64'h0);
        chk("rst_pending", b1.pending, 0);
        chk("rst_busy", b1.busy_mask, 0);
        tick();
        b1.write_en = 2'b00;
        tick();
        reset_n = 1'b1;
        #1;

        // All registers read zero after reset.
        for (int r = 0; r < 32; r++) begin
            b0.rs = {5'd0, 5'(r)};
            #1;
            chk($sformatf("rst_read_x%0d", r), b0.val[31:0], 0);
        end
        chk("rst_busy_b0", b0.busy_mask, 0);

        // Mid-cycle asynchronous reset after writing x5.
        b0.rd = 5'd5; b0.valR = 32'hDEAD_BEEF; b0.write_en = 1'b1;
        tick();
        b0.write_en = 1'b0;
        b0.rs = {5'd0, 5'd5};
        #1;
        chk("x5_written", b0.val[31:0], 32'hDEAD_BEEF);
        reset_n = 1'b0;
        #1;
        chk("x5_async_clear", b0.val[31:0], 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("x5_after_rst", b0.val[31:0], 0);

        // No-bypass write: old value this cycle, new value next cycle.
        b0.rs = {5'd7, 5'd7};
        b0.rd = 5'd7; b0.valR = 32'h1234_5678; b0.write_en = 1'b1;
        #1;
        chk("x7_same_cycle_old", b0.val[31:0], 0);
        tick();
        b0.write_en = 1'b0;
        #1;
        chk("x7_next_cycle", b0.val[31:0], 32'h1234_5678);
        chk("x7_port1", b0.val[63:32], 32'h1234_5678);
        b0.rd = 5'd0; b0.valR = 32'hFFFF_FFFF; b0.write_en = 1'b1;
        tick();
        b0.write_en = 1'b0;
        b0.rs = {5'd7, 5'd0};
        #1;
        chk("x0_reads_zero", b0.val[31:0], 0);
        chk("x7_untouched", b0.val[63:32], 32'h1234_5678);

        // Bypass with two ports to the same register: port 1 wins.
        b1.rs = {5'd0, 5'd3};
        b1.rd = {5'd3, 5'd3};
        b1.valR = {32'h0000_000B, 32'h0000_000A};
        b1.write_en = 2'b11;
        #1;
        chk("byp_prio", b1.val[31:0], 32'h0000_000B);
        tick();
        b1.write_en = 2'b00;
        #1;
        chk("byp_stored", b1.val[31:0], 32'h0000_000B);
        b1.rd = {5'd0, 5'd3};
        b1.valR = {32'h0, 32'h0000_000C};
        b1.write_en = 2'b01;
        #1;
        chk("byp_port0", b1.val[31:0], 32'h0000_000C);
        b1.write_en = 2'b00;

        // Scoreboard claim then retire with bypassed pending drop.
        b1.rs = {5'd9, 5'd3};
        b1.claim_en = 1'b1; b1.claim_rd = 5'd9;
        #1;
        chk("claim_not_yet", b1.busy_mask, 0);
        tick();
        b1.claim_en = 1'b0;
        #1;
        chk("claim_busy9", b1.busy_mask, 64'h200);
        chk("claim_pend9", b1.pending, 2'b10);
        b1.rd = {5'd0, 5'd9};
        b1.valR = {32'h0, 32'h0000_0055};
        b1.write_en = 2'b01;
        #1;
        chk("retire_pend_byp", b1.pending, 2'b00);
        chk("retire_val_byp", b1.val[63:32], 32'h0000_0055);
        chk("retire_busy_raw", b1.busy_mask, 64'h200);
        tick();
        b1.write_en = 2'b00;
        #1;
        chk("retire_busy_clr", b1.busy_mask, 0);
        chk("retire_val", b1.val[63:32], 32'h0000_0055);

        // Claim and write the same register in one cycle: set wins.
        b1.rs = {5'd0, 5'd4};
        b1.claim_en = 1'b1; b1.claim_rd = 5'd4;
        b1.rd = {5'd4, 5'd0};
        b1.valR = {32'h0000_0077, 32'h0};
        b1.write_en = 2'b10;
        tick();
        b1.claim_en = 1'b0;
        b1.write_en = 2'b00;
        #1;
        chk("coll_busy4", b1.busy_mask, 64'h10);
        chk("coll_val4", b1.val[31:0], 32'h0000_0077);
        chk("coll_pend4", b1.pending, 2'b01);
        b1.claim_en = 1'b1; b1.claim_rd = 5'd0;
        tick();
        b1.claim_en = 1'b0;
        #1;
        chk("claim_x0_ignored", b1.busy_mask, 64'h10);

        // Non-power-of-two depth: top register works, 25 is out of range.
        b2.rd = 5'd19; b2.valR = 32'h0000_0019; b2.write_en = 1'b1;
        tick();
        b2.rd = 5'd25; b2.valR = 32'hCAFE_F00D;
        b2.rs = {5'd19, 5'd25};
        #1;
        chk("oob_read_val", b2.val[31:0], 0);
        chk("oob_read_pend", b2.pending, 0);
        chk("x19_stored", b2.val[63:32], 32'h0000_0019);
        tick();
        b2.write_en = 1'b0;
        #1;
        chk("x19_not_clobbered", b2.val[63:32], 32'h0000_0019);
        chk("oob_read_after", b2.val[31:0], 0);
        b2.claim_en = 1'b1; b2.claim_rd = 5'd25;
        tick();
        #1;
        chk("oob_claim", b2.busy_mask, 0);
        b2.claim_rd = 5'd19;
        tick();
        b2.claim_en = 1'b0;
        #1;
        chk("claim_x19", b2.busy_mask, 64'h8_0000);
        chk("pend_x19", b2.pending, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
